// File: rtl/vc_arbitro_dest.sv
// vc_arbitro_dest: strict-priority VC0/VC1 pop arbiter steering words to D0/D1
// with pause back-pressure and per-destination forwarded-word counters.
module vc_arbitro_dest #(
  parameter int DATA_SIZE = 10,
  parameter int DEST_BIT  = 8,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic                 vc0_empty,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 vc1_empty,
  input  logic                 d0_pause,
  input  logic                 d1_pause,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [CNT_SIZE-1:0]  cnt_d0,
  output logic [CNT_SIZE-1:0]  cnt_d1,
  output logic [1:0]           state,
  output logic                 idle
);
  typedef enum logic [1:0] {RESET = 2'b00, INIT = 2'b01, IDLE = 2'b10, ACTIVE = 2'b11} state_t;
  state_t st, nxt;
  logic dst0, dst1, ok0, ok1, pop_any, dst_sel;
  logic [DATA_SIZE-1:0] word;
  assign state = st;
  always_comb begin
    dst0    = vc0_data[DEST_BIT];
    dst1    = vc1_data[DEST_BIT];
    ok0     = !vc0_empty && !(dst0 ? d1_pause : d0_pause);
    ok1     = !vc1_empty && !(dst1 ? d1_pause : d0_pause);
    pop_vc0 = st == ACTIVE && ok0;
    pop_vc1 = st == ACTIVE && ok1 && !ok0;
    pop_any = pop_vc0 || pop_vc1;
    word    = pop_vc0 ? vc0_data : vc1_data;
    dst_sel = pop_vc0 ? dst0 : dst1;
    // IDLE/ACTIVE both reduce to "any VC has data"
    nxt     = st == RESET ? INIT : st == INIT ? IDLE : (vc0_empty && vc1_empty) ? IDLE : ACTIVE;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st       <= RESET;
      idle     <= 1'b0;
      data_out <= '0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      cnt_d0   <= '0;
      cnt_d1   <= '0;
    end else begin
      st      <= nxt;
      idle    <= nxt == IDLE;
      push_d0 <= pop_any && !dst_sel;
      push_d1 <= pop_any && dst_sel;
      cnt_d0  <= cnt_d0 + CNT_SIZE'(pop_any && !dst_sel);
      cnt_d1  <= cnt_d1 + CNT_SIZE'(pop_any && dst_sel);
      if (pop_any) data_out <= word;
    end
  end
endmodule
